// File: rtl/harq_combine_engine_if.sv
// harq_combine_engine_if
//   Bundles the engine's control, RDM stream, combine-buffer and SENDHARQ
//   handoff signals. Signal names carry the engine-side direction prefix.
//   Modports:
//     slave  - the combine engine
//     master - the surrounding system (RDM, buffer, SENDHARQ, control)
interface harq_combine_engine_if #(
  parameter int N_USERS = 8,
  parameter int NCB_W   = 16,
  parameter int LANES   = 8,
  parameter int LLR_W   = 12,
  parameter int ADDR_W  = 11
);
  localparam int UIDX_W = (N_USERS > 1) ? $clog2(N_USERS) : 1;
  localparam int DATA_W = LANES * LLR_W;

  // start / configuration
  logic                     i_comb_req;
  logic [UIDX_W-1:0]        i_user_idx;
  logic                     i_buf_sel;
  logic [N_USERS*NCB_W-1:0] i_users_ncb;
  logic                     i_permit_combine;
  // RDM stream
  logic                     i_rdm_valid;
  logic                     o_rdm_ready;
  logic [DATA_W-1:0]        i_rdm_data;
  logic                     i_rdm_last;
  // combine buffer
  logic [ADDR_W-1:0]        o_buf_rd_addr;
  logic [DATA_W-1:0]        i_buf_rd_data;
  logic                     o_buf_wr_en;
  logic [ADDR_W-1:0]        o_buf_wr_addr;
  logic [DATA_W-1:0]        o_buf_wr_data;
  logic                     o_buf_sel;
  // status
  logic                     o_busy;
  logic [3:0]               o_pass_cnt;
  logic                     o_comb_done;
  logic                     o_cfg_err;
  // SENDHARQ handoff
  logic                     o_harq_req;
  logic [NCB_W-1:0]         o_harq_ncb;
  logic                     o_harq_buf_sel;
  logic                     i_harq_ack;

  modport slave (
    input  i_comb_req, i_user_idx, i_buf_sel, i_users_ncb, i_permit_combine,
    input  i_rdm_valid, i_rdm_data, i_rdm_last, i_buf_rd_data, i_harq_ack,
    output o_rdm_ready, o_buf_rd_addr, o_buf_wr_en, o_buf_wr_addr, o_buf_wr_data,
    output o_buf_sel, o_busy, o_pass_cnt, o_comb_done, o_cfg_err,
    output o_harq_req, o_harq_ncb, o_harq_buf_sel
  );

  modport master (
    output i_comb_req, i_user_idx, i_buf_sel, i_users_ncb, i_permit_combine,
    output i_rdm_valid, i_rdm_data, i_rdm_last, i_buf_rd_data, i_harq_ack,
    input  o_rdm_ready, o_buf_rd_addr, o_buf_wr_en, o_buf_wr_addr, o_buf_wr_data,
    input  o_buf_sel, o_busy, o_pass_cnt, o_comb_done, o_cfg_err,
    input  o_harq_req, o_harq_ncb, o_harq_buf_sel
  );
endinterface

// File: rtl/harq_combine_engine.sv
// harq_combine_engine
//   HARQ soft-combine engine. Streams the RDM LLR words of one code block
//   into an external ping/pong buffer: the first pass over Ncb is written
//   directly, every later pass is saturating-added to the stored words
//   through a 2-stage read-modify-write. The finished buffer is then handed
//   to SENDHARQ with a req/ack handshake.
//   Ports:
//     i_core_clk - core clock, rising edge
//     i_rx_rstn  - asynchronous active-low reset
//     bus        - harq_combine_engine_if.slave (stream, buffer, handoff)
module harq_combine_engine #(
  parameter int N_USERS = 8,
  parameter int NCB_W   = 16,
  parameter int LANES   = 8,
  parameter int LLR_W   = 12,
  parameter int ADDR_W  = 11
) (
  input  logic                  i_core_clk,
  input  logic                  i_rx_rstn,
  harq_combine_engine_if.slave  bus
);
  localparam int DATA_W     = LANES * LLR_W;
  localparam int LOG2_LANES = $clog2(LANES);
  localparam int WORDS_W    = NCB_W - LOG2_LANES;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam logic signed [LLR_W:0] SAT_POS = (LLR_W+1)'(2**(LLR_W-1) - 1);
  localparam logic signed [LLR_W:0] SAT_NEG = -SAT_POS;

  typedef enum logic [2:0] {IDLE, FILL, WAIT, COMBINE, DRAIN, HANDOFF} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   ptr_reg;
  logic [ADDR_W-1:0]   words_m1_reg;
  logic [3:0]          pass_reg;
  logic [NCB_W-1:0]    ncb_reg;
  logic                buf_sel_reg;
  logic                comb_done_reg;
  logic                cfg_err_reg;
  logic                harq_req_reg;
  // combine pipeline stage 2
  logic                pipe_vld_reg;
  logic [ADDR_W-1:0]   pipe_addr_reg;
  logic [DATA_W-1:0]   pipe_data_reg;
  // forwarded write data when stage 1 read the address stage 2 was writing
  logic                byp_vld_reg;
  logic [DATA_W-1:0]   byp_data_reg;

  logic [NCB_W-1:0]    users_ncb [N_USERS];
  logic [NCB_W-1:0]    sel_ncb;
  logic [WORDS_W-1:0]  start_words;
  logic                start_bad;
  logic                rdm_ready;
  logic                accept;
  logic                fill_wr;
  logic                at_end;
  logic                hazard;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   sat_word;
  logic [DATA_W-1:0]   wr_data;

  genvar gi;
  generate
    for (gi = 0; gi < N_USERS; gi++) begin : g_user
      assign users_ncb[gi] = bus.i_users_ncb[gi*NCB_W +: NCB_W];
    end

    // Per-lane add in LLR_W+1 bits, clipped to the symmetric range.
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LLR_W-1:0]        a;
      logic [LLR_W-1:0]        b;
      logic signed [LLR_W:0]   s;
      assign a = pipe_data_reg[gi*LLR_W +: LLR_W];
      assign b = old_word[gi*LLR_W +: LLR_W];
      assign s = $signed({a[LLR_W-1], a}) + $signed({b[LLR_W-1], b});
      assign sat_word[gi*LLR_W +: LLR_W] = (s > SAT_POS) ? SAT_POS[LLR_W-1:0] :
                                           (s < SAT_NEG) ? SAT_NEG[LLR_W-1:0] :
                                                           s[LLR_W-1:0];
    end
  endgenerate

  assign sel_ncb     = users_ncb[bus.i_user_idx];
  assign start_words = sel_ncb[NCB_W-1:LOG2_LANES];
  assign start_bad   = (start_words == '0) || (32'(start_words) > 32'(DEPTH));

  assign rdm_ready = (state_reg == FILL) || (state_reg == COMBINE);
  assign accept    = bus.i_rdm_valid & rdm_ready;
  assign fill_wr   = accept && (state_reg == FILL);
  assign at_end    = (ptr_reg == words_m1_reg);
  assign hazard    = pipe_vld_reg && (pipe_addr_reg == ptr_reg);
  assign old_word  = byp_vld_reg ? byp_data_reg : bus.i_buf_rd_data;
  assign wr_data   = fill_wr      ? bus.i_rdm_data :
                     pipe_vld_reg ? sat_word       : '0;

  assign bus.o_rdm_ready    = rdm_ready;
  assign bus.o_buf_rd_addr  = ptr_reg;
  assign bus.o_buf_wr_en    = fill_wr | pipe_vld_reg;
  assign bus.o_buf_wr_addr  = fill_wr ? ptr_reg : pipe_addr_reg;
  assign bus.o_buf_wr_data  = wr_data;
  assign bus.o_buf_sel      = buf_sel_reg;
  assign bus.o_busy         = (state_reg != IDLE);
  assign bus.o_pass_cnt     = pass_reg;
  assign bus.o_comb_done    = comb_done_reg;
  assign bus.o_cfg_err      = cfg_err_reg;
  assign bus.o_harq_req     = harq_req_reg;
  assign bus.o_harq_ncb     = ncb_reg;
  assign bus.o_harq_buf_sel = buf_sel_reg;

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      words_m1_reg  <= '0;
      pass_reg      <= '0;
      ncb_reg       <= '0;
      buf_sel_reg   <= 1'b0;
      comb_done_reg <= 1'b0;
      cfg_err_reg   <= 1'b0;
      harq_req_reg  <= 1'b0;
      pipe_vld_reg  <= 1'b0;
      pipe_addr_reg <= '0;
      pipe_data_reg <= '0;
      byp_vld_reg   <= 1'b0;
      byp_data_reg  <= '0;
    end else begin
      comb_done_reg <= 1'b0;
      cfg_err_reg   <= 1'b0;

      // Stage 1 of the read-modify-write: the read is issued at ptr this
      // cycle; capture the word, its address and any in-flight write data.
      pipe_vld_reg <= accept && (state_reg == COMBINE);
      byp_vld_reg  <= accept && (state_reg == COMBINE) && hazard;
      if (accept && (state_reg == COMBINE)) begin
        pipe_addr_reg <= ptr_reg;
        pipe_data_reg <= bus.i_rdm_data;
        byp_data_reg  <= wr_data;
      end

      if (accept) begin
        if (at_end) begin
          ptr_reg <= '0;
          if (pass_reg != 4'hF) pass_reg <= pass_reg + 4'd1;
        end else begin
          ptr_reg <= ptr_reg + 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (bus.i_comb_req) begin
            ncb_reg      <= sel_ncb;
            buf_sel_reg  <= bus.i_buf_sel;
            words_m1_reg <= ADDR_W'(start_words - 1'b1);
            ptr_reg      <= '0;
            pass_reg     <= '0;
            if (start_bad) cfg_err_reg <= 1'b1;
            else           state_reg   <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            if (bus.i_rdm_last)            state_reg <= DRAIN;
            else if (at_end)               state_reg <= bus.i_permit_combine ? COMBINE : WAIT;
          end
        end
        WAIT: begin
          if (bus.i_permit_combine) state_reg <= COMBINE;
        end
        COMBINE: begin
          if (accept && bus.i_rdm_last) state_reg <= DRAIN;
        end
        DRAIN: begin
          // the last combine write (if any) retires this cycle
          state_reg     <= HANDOFF;
          comb_done_reg <= 1'b1;
          harq_req_reg  <= 1'b1;
        end
        HANDOFF: begin
          if (bus.i_harq_ack && harq_req_reg) begin
            harq_req_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_harq_combine_engine.sv
// tb_harq_combine_engine
//   Directed bench for harq_combine_engine with a 1-cycle-read buffer model.
module tb_harq_combine_engine;
  localparam int N_USERS = 8;
  localparam int NCB_W   = 16;
  localparam int LANES   = 8;
  localparam int LLR_W   = 12;
  localparam int ADDR_W  = 11;
  localparam int DATA_W  = LANES * LLR_W;

  logic i_core_clk = 1'b0;
  logic i_rx_rstn  = 1'b0;
  always #5 i_core_clk = ~i_core_clk;

  harq_combine_engine_if #(.N_USERS(N_USERS), .NCB_W(NCB_W), .LANES(LANES),
                           .LLR_W(LLR_W), .ADDR_W(ADDR_W)) bus ();

  harq_combine_engine #(.N_USERS(N_USERS), .NCB_W(NCB_W), .LANES(LANES),
                        .LLR_W(LLR_W), .ADDR_W(ADDR_W)) dut (
    .i_core_clk (i_core_clk),
    .i_rx_rstn  (i_rx_rstn),
    .bus        (bus)
  );

  // buffer model: registered read, read-first
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge i_core_clk) begin
    if (bus.o_buf_wr_en) mem[bus.o_buf_wr_addr] <= bus.o_buf_wr_data;
    bus.i_buf_rd_data <= mem[bus.o_buf_rd_addr];
  end

  int cyc    = 0;
  int wr_cnt = 0;
  always @(posedge i_core_clk) begin
    cyc <= cyc + 1;
    if (bus.o_buf_wr_en) wr_cnt <= wr_cnt + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] alt_word(input int ev, input int od);
    logic [DATA_W-1:0] w;
    logic [31:0] e32, o32;
    e32 = ev;
    o32 = od;
    for (int j = 0; j < LANES; j++)
      w[j*LLR_W +: LLR_W] = (j % 2 == 0) ? e32[LLR_W-1:0] : o32[LLR_W-1:0];
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] fill_word(input int v);
    return alt_word(v, v);
  endfunction

  task automatic tick();
    @(posedge i_core_clk);
    #1;
  endtask

  task automatic start(input int user, input logic sel);
    bus.i_user_idx = 3'(user);
    bus.i_buf_sel  = sel;
    bus.i_comb_req = 1'b1;
    tick();
    bus.i_comb_req = 1'b0;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
    int t;
    t = 0;
    bus.i_rdm_valid = 1'b1;
    bus.i_rdm_data  = d;
    bus.i_rdm_last  = last;
    while (!bus.o_rdm_ready && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) check("beat_timeout", 0, 1);
    tick();
    bus.i_rdm_valid = 1'b0;
    bus.i_rdm_last  = 1'b0;
  endtask

  task automatic handoff(input string tag, input logic [15:0] ncb, input logic sel,
                         input logic [3:0] pass);
    int t;
    t = 0;
    while (!bus.o_comb_done && t < 20) begin
      tick();
      t++;
    end
    check({tag, "_done"}, bus.o_comb_done, 1);
    check({tag, "_req"},  bus.o_harq_req, 1);
    check({tag, "_ncb"},  bus.o_harq_ncb, ncb);
    check({tag, "_sel"},  bus.o_harq_buf_sel, sel);
    check({tag, "_pass"}, bus.o_pass_cnt, pass);
    tick();
    check({tag, "_done_pulse"}, bus.o_comb_done, 0);
    bus.i_harq_ack = 1'b1;
    tick();
    bus.i_harq_ack = 1'b0;
    check({tag, "_req_drop"}, {bus.o_harq_req, bus.o_busy}, 2'b00);
    $display("handoff %s ncb=%0d sel=%0d pass=%0d", tag, bus.o_harq_ncb,
             bus.o_harq_buf_sel, bus.o_pass_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, w0;
    bus.i_comb_req = 0; bus.i_user_idx = 0; bus.i_buf_sel = 0;
    bus.i_permit_combine = 1; bus.i_rdm_valid = 0; bus.i_rdm_data = '0;
    bus.i_rdm_last = 0; bus.i_harq_ack = 0;
    bus.i_users_ncb = '0;
    bus.i_users_ncb[0*NCB_W +: NCB_W] = 16'd32;
    bus.i_users_ncb[1*NCB_W +: NCB_W] = 16'd8;
    bus.i_users_ncb[2*NCB_W +: NCB_W] = 16'd64;
    bus.i_users_ncb[3*NCB_W +: NCB_W] = 16'd0;
    bus.i_users_ncb[4*NCB_W +: NCB_W] = 16'h8000;
    bus.i_users_ncb[5*NCB_W +: NCB_W] = 16'd16;
    bus.i_users_ncb[6*NCB_W +: NCB_W] = 16'd16;

    // reset state
    repeat (3) tick();
    check("reset_outputs", {bus.o_busy, bus.o_rdm_ready, bus.o_buf_wr_en, bus.o_pass_cnt,
                            bus.o_comb_done, bus.o_cfg_err, bus.o_harq_req, bus.o_buf_sel}, 0);
    i_rx_rstn = 1'b1;
    tick();

    // partial fill: 5 of 8 words
    w0 = wr_cnt;
    start(2, 1'b1);
    check("pf_busy", {bus.o_busy, bus.o_rdm_ready}, 2'b11);
    for (int k = 0; k < 5; k++) send_beat(fill_word(k + 1), k == 4);
    handoff("pf", 16'd64, 1'b1, 4'd0);
    for (int k = 0; k < 5; k++) check($sformatf("pf_mem%0d", k), mem[k], fill_word(k + 1));
    check("pf_wr_cnt", 32'(wr_cnt - w0), 5);

    // fill plus combine, 4 words, 6 beats, one word per cycle
    start(0, 1'b0);
    c0 = cyc;
    for (int k = 0; k < 6; k++) send_beat(fill_word(100), k == 5);
    check("fc_cycles", 32'(cyc - c0), 6);
    handoff("fc", 16'd32, 1'b0, 4'd1);
    check("fc_mem0", mem[0], fill_word(200));
    check("fc_mem1", mem[1], fill_word(200));
    check("fc_mem2", mem[2], fill_word(100));
    check("fc_mem3", mem[3], fill_word(100));

    // saturation, 2 words
    start(5, 1'b0);
    send_beat(alt_word(2000, -2000), 1'b0);
    send_beat(fill_word(-2048), 1'b0);
    send_beat(alt_word(100, -100), 1'b0);
    send_beat(fill_word(0), 1'b1);
    handoff("sat", 16'd16, 1'b0, 4'd2);
    check("sat_pos_neg", mem[0], alt_word(2047, -2047));
    check("sat_minneg", mem[1], fill_word(-2047));

    // permit gating: WAIT for 10 cycles with a beat pending
    bus.i_permit_combine = 1'b0;
    start(6, 1'b1);
    send_beat(fill_word(1), 1'b0);
    send_beat(fill_word(2), 1'b0);
    check("wait_state", {bus.o_busy, bus.o_rdm_ready}, 2'b10);
    fork
      send_beat(fill_word(5), 1'b1);
      begin
        repeat (10) @(posedge i_core_clk);
        #1;
        check("wait_hold", {bus.o_busy, bus.o_rdm_ready}, 2'b10);
        bus.i_permit_combine = 1'b1;
      end
    join
    handoff("perm", 16'd16, 1'b1, 4'd1);
    check("perm_mem0", mem[0], fill_word(6));
    check("perm_mem1", mem[1], fill_word(2));

    // read-during-write hazard with a 1-word buffer
    start(1, 1'b0);
    send_beat(fill_word(10), 1'b0);
    send_beat(fill_word(20), 1'b0);
    send_beat(fill_word(30), 1'b1);
    handoff("haz", 16'd8, 1'b0, 4'd3);
    check("haz_mem0", mem[0], fill_word(60));

    // bad Ncb values
    w0 = wr_cnt;
    start(3, 1'b0);
    check("err0_pulse", {bus.o_cfg_err, bus.o_busy}, 2'b10);
    tick();
    check("err0_clear", bus.o_cfg_err, 0);
    start(4, 1'b0);
    check("errbig_pulse", {bus.o_cfg_err, bus.o_busy}, 2'b10);
    tick();
    check("err_no_writes", 32'(wr_cnt - w0), 0);

    // start request while busy is ignored
    start(2, 1'b0);
    send_beat(fill_word(7), 1'b0);
    send_beat(fill_word(8), 1'b0);
    start(0, 1'b1);
    check("busy_req_ign", {bus.o_busy, bus.o_buf_sel, bus.o_cfg_err}, 3'b100);
    send_beat(fill_word(9), 1'b1);
    handoff("ign", 16'd64, 1'b0, 4'd0);

    // asynchronous reset mid-COMBINE
    start(0, 1'b1);
    for (int k = 0; k < 5; k++) send_beat(fill_word(3), 1'b0);
    check("pre_rst_pass", bus.o_pass_cnt, 1);
    i_rx_rstn = 1'b0;
    #1;
    check("rst_async", {bus.o_busy, bus.o_rdm_ready, bus.o_buf_wr_en, bus.o_pass_cnt,
                        bus.o_buf_sel, bus.o_harq_req, bus.o_harq_ncb, bus.o_buf_wr_addr,
                        bus.o_buf_rd_addr}, 0);
    check("rst_wr_data", bus.o_buf_wr_data, 0);
    tick();
    i_rx_rstn = 1'b1;
    tick();
    check("rst_idle", {bus.o_busy, bus.o_pass_cnt}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
